// File: rtl/ecc_fifo_d64b.sv
// Synchronous FIFO whose 64-bit entries are stored as 71-bit Hamming SEC codewords.
// The write path encodes (with optional fault injection); the read path corrects combinationally.

module ecc_d64b_p7_enc (
    input  logic [63:0] data,
    output logic [6:0]  parity
);
    // Data bit i sits at the i-th non-power-of-two position of the 1..71 Hamming word.
    function automatic logic [6:0] data_pos(input int idx);
        int          n;
        logic [6:0]  r;
        n = 0;
        r = '0;
        for (int p = 1; p <= 71; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = 7'(p);
                n++;
            end
        end
        return r;
    endfunction

    always_comb begin
        logic [6:0] pos;
        parity = '0;
        pos    = '0;
        for (int i = 0; i < 64; i++) begin
            pos = data_pos(i);
            for (int j = 0; j < 7; j++) begin
                if (pos[j]) parity[j] = parity[j] ^ data[i];
            end
        end
    end
endmodule

module ecc_d64b_p7_dec (
    input  logic [70:0] codeword,
    output logic [63:0] data_corrected,
    output logic        error_flag
);
    logic [6:0] parity_calc;
    logic [6:0] syndrome;

    function automatic logic [6:0] data_pos(input int idx);
        int          n;
        logic [6:0]  r;
        n = 0;
        r = '0;
        for (int p = 1; p <= 71; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = 7'(p);
                n++;
            end
        end
        return r;
    endfunction

    ecc_d64b_p7_enc u_recalc (
        .data   (codeword[63:0]),
        .parity (parity_calc)
    );

    assign syndrome   = codeword[70:64] ^ parity_calc;
    assign error_flag = |syndrome;

    // A syndrome equal to a power of two points at a parity bit, so no data bit flips.
    always_comb begin
        data_corrected = codeword[63:0];
        for (int i = 0; i < 64; i++) begin
            if (syndrome == data_pos(i)) data_corrected[i] = ~codeword[i];
        end
    end
endmodule

module ecc_fifo_d64b #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [63:0]                wr_data,
    input  logic                       inj_en,
    input  logic [70:0]                inj_mask,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [63:0]                rd_data,
    output logic                       rd_err,
    output logic [CNT_W-1:0]           err_cnt,
    input  logic                       err_cnt_clr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [70:0]       mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [70:0]       wr_word_d;
    logic [6:0]        wr_parity;
    logic              wr_en;
    logic              rd_en;

    ecc_d64b_p7_enc u_enc (
        .data   (wr_data),
        .parity (wr_parity)
    );

    ecc_d64b_p7_dec u_dec (
        .codeword       (mem_q[rd_ptr_q]),
        .data_corrected (rd_data),
        .error_flag     (rd_err)
    );

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign wr_ready = !full && !rst;
    assign rd_valid = !empty;
    assign count    = count_q;
    assign err_cnt  = err_cnt_q;
    assign wr_en    = wr_valid && wr_ready;
    assign rd_en    = rd_valid && rd_ready && !rst;

    always_comb begin
        wr_word_d = {wr_parity, wr_data} ^ (inj_en ? inj_mask : 71'd0);
        wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (wr_en && !rd_en) count_d = count_q + 1'b1;
        else if (rd_en && !wr_en) count_d = count_q - 1'b1;
        // Clear beats increment; the counter sticks at all-ones instead of wrapping.
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) err_cnt_d = '0;
        else if (rd_en && rd_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_word_d;
    end
endmodule
